dbus_periph_router: RTL and testbench
=====================================

# dbus_periph_router

Data-bus peripheral router between the LSU data-bus port and the memory-mapped slaves (boot memory, UART, CLINT, PLIC). It decodes each data-bus request address and drives the matching per-slave select, including the boot-memory `bmem_d_sel` consumed by the boot memory interface. It muxes the selected slave's registered response back to the LSU. A single-outstanding FSM with a timeout turns unmapped or hung accesses into error acknowledges.

## Interface
Parameters:
- `TIMEOUT`, 255: BUSY cycles without slave ack before an error ack is issued; legal range 2..1023.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `dbus2peri_i`  in  type_dbus2peri_s  request from LSU (`req`, `addr`, `w_en`, write data, byte select)
- `peri2dbus_o`  out  type_peri2dbus_s  response to LSU (`ack`, `r_data`)
- `dbus_err_o`  out  1  qualifies `peri2dbus_o.ack` as an error completion
- `dbus2peri_o`  out  type_dbus2peri_s  request broadcast to all slaves; equals `dbus2peri_i`
- `bmem_d_sel_o`, `uart_sel_o`, `clint_sel_o`, `plic_sel_o`  out  1 each  one-hot slave selects
- `bmem2dbus_i`, `uart2dbus_i`, `clint2dbus_i`, `plic2dbus_i`  in  type_peri2dbus_s  slave responses

## Operation
- Address map, decoded on the full 32-bit `addr`:
  - BMEM: 0x0000_1000–0x0000_1FFF
  - CLINT: 0x0200_0000–0x0200_FFFF
  - PLIC: 0x0C00_0000–0x0CFF_FFFF
  - UART: 0x9000_0000–0x9000_00FF
  - Anything else: unmapped.
- FSM states are IDLE, BUSY and ERR.
- IDLE:
  - On `req`, latch the decoded slave index and clear the timeout counter.
  - Mapped address: go to BUSY.
  - Unmapped address: go to ERR.
  - With no `req`, stay in IDLE.
- BUSY:
  - The select for the latched slave is high; all other selects are low.
  - `peri2dbus_o` is the latched slave's response, passed through combinationally.
  - When that slave's `ack` = 1: assert ack to the LSU with `dbus_err_o` = 0, then go to IDLE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`-1 without an ack, go to ERR.
- ERR: for one cycle drive `ack` = 1, `r_data` = 0 and `dbus_err_o` = 1, then go to IDLE.
- Acks from non-selected slaves are ignored in every state.
- The LSU holds `req` and `addr` stable until ack. If `req` drops while in BUSY, the router still waits for the slave ack or timeout; the resulting ack is produced and not suppressed.
- A new `req` in the cycle immediately after an ack is accepted: IDLE decodes it normally.
- Writes to BMEM are routed like reads. BMEM ignores write data; the completion is a normal ack.
- Reset, including mid-transaction: state goes to IDLE, counter to 0, all selects 0, `peri2dbus_o` = '0 and `dbus_err_o` = 0. A slave ack arriving after reset is ignored.

## Timing
- Selects and the state are registered; the response path is combinational from the slave inputs.
- BMEM read:
  - `req` seen in IDLE at cycle 0.
  - `bmem_d_sel_o` = 1 from cycle 1.
  - BMEM registered ack appears at cycle 2 and is forwarded in cycle 2; select drops in cycle 3.
  - The boot memory interface's `~ack` guard prevents a double ack in cycle 2.
- General latency is 1 + slave latency cycles.
- Unmapped access: ack + err in cycle 1.
- Timeout: err ack in cycle `TIMEOUT`+1 after the request cycle.
- `peri2dbus_o.ack` is never high for two consecutive cycles for the same request.

## Structure
- Shared package (`pcore_config_defs`):
  - address base/mask constants `BMEM_BASE`, `BMEM_MASK`, `CLINT_BASE`, `CLINT_MASK`, `PLIC_BASE`, `PLIC_MASK`, `UART_BASE`, `UART_MASK`
  - enum `type_periph_sel_e` {SEL_NONE, SEL_BMEM, SEL_UART, SEL_CLINT, SEL_PLIC}
  - enum `type_router_state_e`
- Sub-module `dbus_addr_decode`: purely combinational, `addr` → `type_periph_sel_e`. It is reused by the IF-side boot address match.

## Test plan
- Read 0x0000_1004 with BMEM model returning 0xDEADBEEF: `bmem_d_sel_o` high in cycles 1–2; ack = 1 with `r_data` = 0xDEADBEEF in cycle 2; `dbus_err_o` = 0; exactly one ack.
- Read 0x4000_0000 (unmapped): ack = 1, err = 1, `r_data` = 0 in cycle 1; no select ever asserts.
- CLINT model that never acks, `TIMEOUT` = 8: `clint_sel_o` high in cycles 1–8; err ack in cycle 9; back in IDLE in cycle 10.
- Back-to-back UART then PLIC requests, with a stray ack from the non-selected UART during the PLIC access: the stray ack is ignored. The PLIC ack is forwarded only when the PLIC acks; each request completes exactly once.
- Assert `rst_n` low during BUSY on a BMEM access: all outputs are 0 immediately (async); the late BMEM ack is not forwarded. The next request after reset completes normally.
- Request to 0x0000_1FFC and to 0x0000_2000 (the BMEM boundary): the first selects BMEM; the second returns an err ack in cycle 1.

Source files
------------

// File: rtl/pcore_config_defs.sv
// Shared core configuration: data-bus payload types, slave address map,
// peripheral select / router state enums and small decode helpers.
package pcore_config_defs;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BSEL_W = XLEN / 8;
  localparam int unsigned NSLV   = 4;

  // A slave matches when (addr & MASK) == BASE
  localparam logic [XLEN-1:0] BMEM_BASE  = 32'h0000_1000;
  localparam logic [XLEN-1:0] BMEM_MASK  = 32'hFFFF_F000;
  localparam logic [XLEN-1:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [XLEN-1:0] CLINT_MASK = 32'hFFFF_0000;
  localparam logic [XLEN-1:0] PLIC_BASE  = 32'h0C00_0000;
  localparam logic [XLEN-1:0] PLIC_MASK  = 32'hFF00_0000;
  localparam logic [XLEN-1:0] UART_BASE  = 32'h9000_0000;
  localparam logic [XLEN-1:0] UART_MASK  = 32'hFFFF_FF00;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_BMEM,
    SEL_UART,
    SEL_CLINT,
    SEL_PLIC
  } type_periph_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ERR
  } type_router_state_e;

  typedef struct packed {
    logic              req;
    logic [XLEN-1:0]   addr;
    logic              w_en;
    logic [XLEN-1:0]   w_data;
    logic [BSEL_W-1:0] b_sel;
  } type_dbus2peri_s;

  typedef struct packed {
    logic            ack;
    logic [XLEN-1:0] r_data;
  } type_peri2dbus_s;

  function automatic logic addr_hit(input logic [XLEN-1:0] addr,
                                    input logic [XLEN-1:0] base,
                                    input logic [XLEN-1:0] mask);
    return (addr & mask) == base;
  endfunction

  // One-hot select vector, bit order {plic, clint, uart, bmem}
  function automatic logic [NSLV-1:0] sel_onehot(input type_periph_sel_e sel);
    logic [NSLV-1:0] oh;
    oh = '0;
    case (sel)
      SEL_BMEM:  oh[0] = 1'b1;
      SEL_UART:  oh[1] = 1'b1;
      SEL_CLINT: oh[2] = 1'b1;
      SEL_PLIC:  oh[3] = 1'b1;
      default:   oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dbus_periph_router_if.sv
// LSU-side data-bus port: request, response and error qualifier.
//   master: LSU (drives dbus2peri, receives peri2dbus/dbus_err)
//   slave : router (receives dbus2peri, drives peri2dbus/dbus_err)
interface dbus_periph_router_if;
  import pcore_config_defs::*;

  type_dbus2peri_s dbus2peri;
  type_peri2dbus_s peri2dbus;
  logic            dbus_err;

  modport master (output dbus2peri, input  peri2dbus, input  dbus_err);
  modport slave  (input  dbus2peri, output peri2dbus, output dbus_err);

endinterface

// File: rtl/dbus_addr_decode.sv
// Combinational address decoder: full 32-bit address to peripheral select.
// Shared with the IF-side boot address match.
//   addr : byte address
//   sel  : matching slave, SEL_NONE when unmapped
module dbus_addr_decode
  import pcore_config_defs::*;
(
  input  logic [XLEN-1:0]  addr,
  output type_periph_sel_e sel
);

  always_comb begin
    sel = SEL_NONE;
    if (addr_hit(addr, BMEM_BASE, BMEM_MASK)) begin
      sel = SEL_BMEM;
    end else if (addr_hit(addr, CLINT_BASE, CLINT_MASK)) begin
      sel = SEL_CLINT;
    end else if (addr_hit(addr, PLIC_BASE, PLIC_MASK)) begin
      sel = SEL_PLIC;
    end else if (addr_hit(addr, UART_BASE, UART_MASK)) begin
      sel = SEL_UART;
    end
  end

endmodule

// File: rtl/dbus_periph_router.sv
// Data-bus peripheral router: decodes LSU requests onto one-hot slave
// selects, muxes the selected slave's response back, and converts unmapped
// or timed-out accesses into error acknowledges. One access outstanding.
//   clk, rst_n          : clock, async active-low reset
//   dbus                : LSU port (request in, response + error out)
//   dbus2peri_o         : request broadcast to every slave
//   *_sel_o             : registered one-hot slave selects
//   *2dbus_i            : slave responses
module dbus_periph_router
  import pcore_config_defs::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dbus_periph_router_if.slave  dbus,
  output type_dbus2peri_s      dbus2peri_o,
  output logic                 bmem_d_sel_o,
  output logic                 uart_sel_o,
  output logic                 clint_sel_o,
  output logic                 plic_sel_o,
  input  type_peri2dbus_s      bmem2dbus_i,
  input  type_peri2dbus_s      uart2dbus_i,
  input  type_peri2dbus_s      clint2dbus_i,
  input  type_peri2dbus_s      plic2dbus_i
);

  localparam int unsigned CNT_W = 10;

  type_router_state_e state;
  type_periph_sel_e   slave_q;
  type_periph_sel_e   dec_sel;
  logic [CNT_W-1:0]   cnt;
  logic [NSLV-1:0]    sel_q;

  type_peri2dbus_s    rsp;
  logic               err;
  logic               slave_ack;

  assign dbus2peri_o = dbus.dbus2peri;

  dbus_addr_decode u_dec (
    .addr (dbus.dbus2peri.addr),
    .sel  (dec_sel)
  );

  // Response mux; only the latched slave can complete a BUSY access
  always_comb begin
    rsp       = '0;
    err       = 1'b0;
    slave_ack = 1'b0;
    case (state)
      ST_BUSY: begin
        case (slave_q)
          SEL_BMEM:  rsp = bmem2dbus_i;
          SEL_UART:  rsp = uart2dbus_i;
          SEL_CLINT: rsp = clint2dbus_i;
          SEL_PLIC:  rsp = plic2dbus_i;
          default:   rsp = '0;
        endcase
        slave_ack = rsp.ack;
      end
      ST_ERR: begin
        rsp.ack = 1'b1;
        err     = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbus.peri2dbus = rsp;
  assign dbus.dbus_err  = err;

  // Single-outstanding FSM with timeout; selects registered alongside state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      slave_q <= SEL_NONE;
      cnt     <= '0;
      sel_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dbus.dbus2peri.req) begin
            slave_q <= dec_sel;
            cnt     <= '0;
            if (dec_sel != SEL_NONE) begin
              state <= ST_BUSY;
              sel_q <= sel_onehot(dec_sel);
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_BUSY: begin
          if (slave_ack) begin
            state <= ST_IDLE;
            sel_q <= '0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state <= ST_ERR;
            sel_q <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          sel_q <= '0;
        end
      endcase
    end
  end

  assign bmem_d_sel_o = sel_q[0];
  assign uart_sel_o   = sel_q[1];
  assign clint_sel_o  = sel_q[2];
  assign plic_sel_o   = sel_q[3];

endmodule

// File: tb/tb_dbus_periph_router.sv
// Directed self-checking bench for dbus_periph_router (TIMEOUT = 8).
// BMEM is a registered-ack model with the ~ack guard; other slaves are
// driven directly from the stimulus sequence.
module tb_dbus_periph_router;
  import pcore_config_defs::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dbus_periph_router_if dbus_if();

  type_dbus2peri_s bcast;
  logic            bmem_sel, uart_sel, clint_sel, plic_sel;
  type_peri2dbus_s bmem_rsp, uart_rsp, clint_rsp, plic_rsp;
  logic            bmem_ack_q;
  logic            bmem_late;

  int n_pass  = 0;
  int n_total = 0;

  dbus_periph_router #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dbus         (dbus_if),
    .dbus2peri_o  (bcast),
    .bmem_d_sel_o (bmem_sel),
    .uart_sel_o   (uart_sel),
    .clint_sel_o  (clint_sel),
    .plic_sel_o   (plic_sel),
    .bmem2dbus_i  (bmem_rsp),
    .uart2dbus_i  (uart_rsp),
    .clint2dbus_i (clint_rsp),
    .plic2dbus_i  (plic_rsp)
  );

  // Boot memory: registered ack one cycle after select, never two in a row
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bmem_ack_q <= 1'b0;
    else        bmem_ack_q <= bmem_sel & ~bmem_ack_q;
  end

  always_comb begin
    bmem_rsp.ack    = bmem_ack_q | bmem_late;
    bmem_rsp.r_data = bmem_rsp.ack ? 32'hDEAD_BEEF : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chk_sels(input string tag, input logic [3:0] exp);
    chk(tag, 32'({plic_sel, clint_sel, uart_sel, bmem_sel}), 32'(exp));
  endtask

  task automatic chk_rsp(input string tag, input logic ack, input logic err,
                         input logic [31:0] rdata);
    chk({tag, "_ack"},   32'(dbus_if.peri2dbus.ack), 32'(ack));
    chk({tag, "_err"},   32'(dbus_if.dbus_err),      32'(err));
    chk({tag, "_rdata"}, dbus_if.peri2dbus.r_data,   rdata);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, 32'(dbus_if.peri2dbus.ack), 32'(0));
    chk({tag, "_err"}, 32'(dbus_if.dbus_err),      32'(0));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic send(input logic [31:0] addr, input logic w_en);
    dbus_if.dbus2peri.req    = 1'b1;
    dbus_if.dbus2peri.addr   = addr;
    dbus_if.dbus2peri.w_en   = w_en;
    dbus_if.dbus2peri.w_data = 32'h5555_AAAA;
    dbus_if.dbus2peri.b_sel  = 4'hF;
  endtask

  initial begin
    dbus_if.dbus2peri = '0;
    uart_rsp  = '0;
    clint_rsp = '0;
    plic_rsp  = '0;
    bmem_late = 1'b0;

    // Reset state
    #12;
    chk_sels("rst_sels", 4'b0000);
    chk_rsp("rst", 1'b0, 1'b0, 32'h0);
    #5 rst_n = 1'b1;

    // BMEM read 0x1004
    next_cycle(); send(32'h0000_1004, 1'b0); settle();
    chk_sels("bmem_c0_sels", 4'b0000);
    chk_quiet("bmem_c0");
    chk("bcast_addr", bcast.addr, 32'h0000_1004);
    next_cycle(); settle();
    chk_sels("bmem_c1_sels", 4'b0001);
    chk_quiet("bmem_c1");
    next_cycle(); settle();
    chk_sels("bmem_c2_sels", 4'b0001);
    chk_rsp("bmem_c2", 1'b1, 1'b0, 32'hDEAD_BEEF);
    next_cycle(); dbus_if.dbus2peri.req = 1'b0; settle();
    chk_sels("bmem_c3_sels", 4'b0000);
    chk_quiet("bmem_c3");
    next_cycle(); settle();
    chk_quiet("bmem_c4");

    // Unmapped 0x4000_0000 with a non-zero idle CLINT response present
    next_cycle(); send(32'h4000_0000, 1'b0); clint_rsp.r_data = 32'h1234_5678; settle();
    chk_quiet("unm_c0");
    next_cycle(); settle();
    chk_sels("unm_c1_sels", 4'b0000);
    chk_rsp("unm_c1", 1'b1, 1'b1, 32'h0);
    next_cycle(); dbus_if.dbus2peri.req = 1'b0; settle();
    chk_sels("unm_c2_sels", 4'b0000);
    chk_quiet("unm_c2");

    // CLINT never acks: timeout after 8 BUSY cycles
    next_cycle(); send(32'h0200_4000, 1'b0); settle();
    chk_quiet("to_c0");
    for (int i = 1; i <= 8; i++) begin
      next_cycle(); settle();
      chk_sels($sformatf("to_c%0d_sels", i), 4'b0100);
      chk_quiet($sformatf("to_c%0d", i));
    end
    next_cycle(); settle();
    chk_sels("to_c9_sels", 4'b0000);
    chk_rsp("to_c9", 1'b1, 1'b1, 32'h0);
    next_cycle(); dbus_if.dbus2peri.req = 1'b0; clint_rsp = '0; settle();
    chk_sels("to_c10_sels", 4'b0000);
    chk_quiet("to_c10");

    // UART then PLIC back-to-back, stray UART ack during PLIC access
    next_cycle(); send(32'h9000_0010, 1'b0); settle();
    chk_quiet("uart_c0");
    next_cycle(); settle();
    chk_sels("uart_c1_sels", 4'b0010);
    chk_quiet("uart_c1");
    next_cycle(); uart_rsp.ack = 1'b1; uart_rsp.r_data = 32'h0000_00A5; settle();
    chk_rsp("uart_c2", 1'b1, 1'b0, 32'h0000_00A5);
    next_cycle(); uart_rsp = '0; send(32'h0C00_0100, 1'b0); settle();
    chk_sels("plic_c0_sels", 4'b0000);
    chk_quiet("plic_c0");
    next_cycle(); uart_rsp.ack = 1'b1; uart_rsp.r_data = 32'h0000_0BAD; settle();
    chk_sels("plic_c1_sels", 4'b1000);
    chk_quiet("plic_c1_stray");
    next_cycle(); uart_rsp = '0; plic_rsp.ack = 1'b1; plic_rsp.r_data = 32'h0000_0C0C; settle();
    chk_sels("plic_c2_sels", 4'b1000);
    chk_rsp("plic_c2", 1'b1, 1'b0, 32'h0000_0C0C);
    next_cycle(); plic_rsp = '0; dbus_if.dbus2peri.req = 1'b0; settle();
    chk_sels("plic_c3_sels", 4'b0000);
    chk_quiet("plic_c3");

    // Reset during a BMEM access, late BMEM ack afterwards
    next_cycle(); send(32'h0000_1008, 1'b0); settle();
    next_cycle(); settle();
    chk_sels("rb_c1_sels", 4'b0001);
    #1 rst_n = 1'b0;
    #1;
    chk_sels("rb_async_sels", 4'b0000);
    chk_quiet("rb_async");
    dbus_if.dbus2peri.req = 1'b0;
    next_cycle(); #3 rst_n = 1'b1;
    next_cycle(); bmem_late = 1'b1; settle();
    chk_sels("rb_late_sels", 4'b0000);
    chk_rsp("rb_late", 1'b0, 1'b0, 32'h0);
    next_cycle(); bmem_late = 1'b0; settle();

    // BMEM write after reset completes normally
    next_cycle(); send(32'h0000_1010, 1'b1); settle();
    next_cycle(); settle();
    chk_sels("wr_c1_sels", 4'b0001);
    next_cycle(); settle();
    chk_rsp("wr_c2", 1'b1, 1'b0, 32'hDEAD_BEEF);
    next_cycle(); dbus_if.dbus2peri.req = 1'b0; settle();
    chk_quiet("wr_c3");

    // BMEM boundary: last word maps, next address does not
    next_cycle(); send(32'h0000_1FFC, 1'b0); settle();
    next_cycle(); settle();
    chk_sels("top_c1_sels", 4'b0001);
    next_cycle(); settle();
    chk_rsp("top_c2", 1'b1, 1'b0, 32'hDEAD_BEEF);
    next_cycle(); dbus_if.dbus2peri.req = 1'b0; settle();
    chk_quiet("top_c3");
    next_cycle(); send(32'h0000_2000, 1'b0); settle();
    chk_quiet("past_c0");
    next_cycle(); settle();
    chk_sels("past_c1_sels", 4'b0000);
    chk_rsp("past_c1", 1'b1, 1'b1, 32'h0);
    next_cycle(); dbus_if.dbus2peri.req = 1'b0; settle();
    chk_quiet("past_c2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
